// File: rtl/rvs192_wb_pkg.sv
// ----------------------------------------------------------------------------
// rvs192_wb_pkg: shared types and byte-merge helper for the store buffer. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rvs192_wb_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_ADDR_W     = 30;
  localparam int WB_BE_W       = WB_DATA_W / 8;
  // Widest data path the merge helper supports; callers zero-extend and truncate.
  localparam int WB_MAX_DATA_W = 1024;
  localparam int WB_MAX_BE_W   = WB_MAX_DATA_W / 8;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_BE_W-1:0]   be;
  } wb_entry_t;

  function automatic logic [WB_MAX_DATA_W-1:0] merge_bytes(
    input logic [WB_MAX_DATA_W-1:0] old_data,
    input logic [WB_MAX_DATA_W-1:0] new_data,
    input logic [WB_MAX_BE_W-1:0]   be
  );
    logic [WB_MAX_DATA_W-1:0] res;
    for (int i = 0; i < WB_MAX_BE_W; i++) begin
      res[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_addr_cam.sv
// ----------------------------------------------------------------------------
// wb_addr_cam: per-entry address comparators, one-hot/encoded match, head flag. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_addr_cam #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 30,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH*ADDR_W-1:0] addrs,
  input  logic [ADDR_W-1:0]       key,
  input  logic [IDX_W-1:0]        head_idx,
  output logic [DEPTH-1:0]        match,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output logic                    is_head
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = valid[i] && (addrs[i*ADDR_W +: ADDR_W] == key);
  end

  // Coalescing guarantees at most one valid entry per address, so OR-encoding is exact.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) idx = idx | IDX_W'(i);
    end
  end

  assign hit     = |match;
  assign is_head = hit && (idx == head_idx);

endmodule

`default_nettype wire

// File: rtl/coalescing_write_buffer.sv
// ----------------------------------------------------------------------------
// coalescing_write_buffer: byte-merging store buffer with in-order drain. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module coalescing_write_buffer
  import rvs192_wb_pkg::*;
#(
  parameter  int DATA_W   = WB_DATA_W,
  parameter  int ADDR_W   = WB_ADDR_W,
  parameter  int DEPTH    = 8,
  parameter  int DRAIN_TH = 4,
  localparam int BE_W     = DATA_W / 8,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [BE_W-1:0]   st_be,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic [BE_W-1:0]   ld_be,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [BE_W-1:0]   mem_be,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  logic [DEPTH-1:0]        valid_q;
  logic [ADDR_W-1:0]       addr_q [DEPTH];
  logic [DATA_W-1:0]       data_q [DEPTH];
  logic [BE_W-1:0]         be_q   [DEPTH];
  logic [DEPTH*ADDR_W-1:0] addr_flat;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        wr_idx;
  logic [CNT_W-1:0]        count_q;
  logic                    draining;

  logic [DEPTH-1:0] st_match;
  logic             st_hit;
  logic [IDX_W-1:0] st_idx;
  logic             st_is_head;
  logic [DEPTH-1:0] ld_match;
  logic [IDX_W-1:0] ld_idx;
  logic             ld_is_head;
  logic             unused_cam;

  logic full;
  logic st_fire;
  logic alloc;
  logic merge;
  logic pop;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign addr_flat[i*ADDR_W +: ADDR_W] = addr_q[i];
  end

  wb_addr_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_st_cam (
    .valid    (valid_q),
    .addrs    (addr_flat),
    .key      (st_addr),
    .head_idx (rd_idx),
    .match    (st_match),
    .hit      (st_hit),
    .idx      (st_idx),
    .is_head  (st_is_head)
  );

  wb_addr_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_ld_cam (
    .valid    (valid_q),
    .addrs    (addr_flat),
    .key      (ld_addr),
    .head_idx (rd_idx),
    .match    (ld_match),
    .hit      (ld_hit),
    .idx      (ld_idx),
    .is_head  (ld_is_head)
  );

  assign unused_cam = ^{st_match, ld_match, ld_is_head};

  // Decisions use registered occupancy only; a same-cycle pop never frees a slot.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign st_ready = st_hit ? !st_is_head : !full;
  assign st_fire  = st_valid && st_ready;
  // A zero-enable store that misses carries no bytes, so it is absorbed without a slot.
  assign alloc    = st_fire && !st_hit && (|st_be);
  assign merge    = st_fire && st_hit;
  assign pop      = draining && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (pop) valid_q[rd_idx] <= 1'b0;
      if (alloc) begin
        valid_q[wr_idx] <= 1'b1;
        addr_q[wr_idx]  <= st_addr;
        data_q[wr_idx]  <= DATA_W'(merge_bytes('0, WB_MAX_DATA_W'(st_data),
                                               WB_MAX_BE_W'(st_be)));
        be_q[wr_idx]    <= st_be;
      end
      if (merge) begin
        data_q[st_idx] <= DATA_W'(merge_bytes(WB_MAX_DATA_W'(data_q[st_idx]),
                                              WB_MAX_DATA_W'(st_data),
                                              WB_MAX_BE_W'(st_be)));
        be_q[st_idx]   <= be_q[st_idx] | st_be;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx   <= '0;
      wr_idx   <= '0;
      count_q  <= '0;
      draining <= 1'b0;
    end else begin
      if (pop)   rd_idx <= (rd_idx == IDX_LAST) ? '0 : rd_idx + 1'b1;
      if (alloc) wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
      if (pop) begin
        draining <= 1'b0;
      end else if (!draining && (count_q != '0) &&
                   (flush || (count_q >= CNT_W'(DRAIN_TH)))) begin
        draining <= 1'b1;
      end
    end
  end

  // Stored data already has disabled bytes zeroed, so only the miss case needs masking.
  assign ld_data = ld_hit ? data_q[ld_idx] : '0;
  assign ld_be   = ld_hit ? be_q[ld_idx]   : '0;

  assign mem_valid = draining;
  assign mem_addr  = addr_q[rd_idx];
  assign mem_data  = data_q[rd_idx];
  assign mem_be    = be_q[rd_idx];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_coalescing_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_coalescing_write_buffer: directed self-checking bench for the store buffer. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_coalescing_write_buffer;
  import rvs192_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [29:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic [29:0] ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;
  logic        flush = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [3:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  wb_entry_t exp_q[$];

  always #5 clk = ~clk;

  coalescing_write_buffer #(.DATA_W(32), .ADDR_W(30), .DEPTH(8), .DRAIN_TH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_be     (st_be),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .ld_be     (ld_be),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_be    (mem_be),
    .count     (count),
    .empty     (empty)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wb_entry_t mk(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
    return '{valid: 1'b1, addr: a, data: d, be: b};
  endfunction

  task automatic do_store(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
    int n = 0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = b;
    #1;
    while (!st_ready && n < 50) begin
      tick();
      n++;
    end
    chk("store_accept", 128'(st_ready), 128'(1));
    tick();
    st_valid = 1'b0;
  endtask

  task automatic chk_ld(input string tag, input logic [29:0] a, input logic h,
                        input logic [31:0] d, input logic [3:0] b);
    ld_addr = a;
    #1;
    chk(tag, 128'({ld_hit, ld_data, ld_be}), 128'({h, d, b}));
  endtask

  // Holds flush with random bus backpressure until every queued beat is seen in order.
  task automatic drain_expected(input int bound);
    int n = 0;
    flush = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (mem_valid && mem_ready) begin
        wb_entry_t e = exp_q.pop_front();
        chk("drain_beat", 128'({mem_addr, mem_data, mem_be}), 128'({e.addr, e.data, e.be}));
      end
      tick();
      n++;
    end
    flush = 1'b0;
    mem_ready = 1'b0;
    chk("drain_all_seen", 128'(exp_q.size()), 128'(0));
    chk("drain_empty", 128'({empty, count, mem_valid}), 128'({1'b1, 4'd0, 1'b0}));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_state", 128'({count, empty, mem_valid, st_ready}), 128'({4'd0, 1'b1, 1'b0, 1'b1}));
    chk_ld("rst_ld", 30'h10, 1'b0, 32'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single store forwards next cycle; below threshold nothing drains
    do_store(30'h10, 32'h11223344, 4'hF);
    chk_ld("fwd_full_word", 30'h10, 1'b1, 32'h11223344, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("below_th_idle", 128'({count, mem_valid}), 128'({4'd1, 1'b0}));
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_beat0", 128'({mem_valid, mem_addr, mem_data, mem_be}),
        128'({1'b1, 30'h10, 32'h11223344, 4'hF}));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("after_pop0", 128'({count, empty, mem_valid}), 128'({4'd0, 1'b1, 1'b0}));

    // Store matching the head stalls until the head pops, then allocates a new entry
    do_store(30'h10, 32'h000000AA, 4'h1);
    do_store(30'h20, 32'h12345678, 4'hF);
    st_valid = 1'b1;
    st_addr  = 30'h10;
    st_data  = 32'h0000BB00;
    st_be    = 4'h2;
    #1;
    chk("head_stall", 128'(st_ready), 128'(0));
    flush = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("head_beat", 128'({mem_valid, mem_addr, mem_data, mem_be}),
        128'({1'b1, 30'h10, 32'h000000AA, 4'h1}));
    chk("head_stall_pop_cycle", 128'(st_ready), 128'(0));
    tick();
    flush = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("after_head_pop", 128'({st_ready, mem_valid, count}), 128'({1'b1, 1'b0, 4'd1}));
    tick();
    st_valid = 1'b0;
    chk_ld("realloc_0x10", 30'h10, 1'b1, 32'h0000BB00, 4'h2);
    chk("realloc_count", 128'(count), 128'(2));

    // Merge into a non-head entry
    do_store(30'h30, 32'h30303030, 4'hF);
    do_store(30'h40, 32'h000000CD, 4'h1);
    do_store(30'h40, 32'h0000EF00, 4'h2);
    chk_ld("merge_0x40", 30'h40, 1'b1, 32'h0000EFCD, 4'h3);
    chk("merge_count_drain", 128'({count, mem_valid, mem_addr}), 128'({4'd4, 1'b1, 30'h20}));

    // Fill to DEPTH with the bus stalled
    do_store(30'h50, 32'h50505050, 4'hF);
    do_store(30'h60, 32'h60606060, 4'hF);
    do_store(30'h70, 32'h70707070, 4'hF);
    do_store(30'h80, 32'h80808080, 4'hF);
    chk("full_count", 128'({count, empty}), 128'({4'd8, 1'b0}));
    st_valid = 1'b1;
    st_addr  = 30'h90;
    st_data  = 32'h90909090;
    st_be    = 4'hF;
    #1;
    chk("full_new_addr_stall", 128'(st_ready), 128'(0));
    tick();
    st_valid = 1'b0;
    do_store(30'h30, 32'h000000AA, 4'h1);
    chk_ld("full_merge_0x30", 30'h30, 1'b1, 32'h303030AA, 4'hF);
    chk("full_merge_count", 128'(count), 128'(8));
    for (int i = 0; i < 10; i++) begin
      chk("hold_payload", 128'({mem_valid, mem_addr, mem_data, mem_be}),
          128'({1'b1, 30'h20, 32'h12345678, 4'hF}));
      tick();
    end

    // Store to the head while full: stalls, head pops, store lands at the tail
    st_valid = 1'b1;
    st_addr  = 30'h20;
    st_data  = 32'h22222222;
    st_be    = 4'hF;
    #1;
    chk("full_head_stall", 128'(st_ready), 128'(0));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("head_free_ready", 128'({st_ready, count}), 128'({1'b1, 4'd7}));
    tick();
    st_valid = 1'b0;
    chk("tail_alloc_count", 128'(count), 128'(8));

    // Drain everything in allocation order across the index wrap
    exp_q.push_back(mk(30'h10, 32'h0000BB00, 4'h2));
    exp_q.push_back(mk(30'h30, 32'h303030AA, 4'hF));
    exp_q.push_back(mk(30'h40, 32'h0000EFCD, 4'h3));
    exp_q.push_back(mk(30'h50, 32'h50505050, 4'hF));
    exp_q.push_back(mk(30'h60, 32'h60606060, 4'hF));
    exp_q.push_back(mk(30'h70, 32'h70707070, 4'hF));
    exp_q.push_back(mk(30'h80, 32'h80808080, 4'hF));
    exp_q.push_back(mk(30'h20, 32'h22222222, 4'hF));
    drain_expected(400);

    // One-cycle flush pulse with three entries releases only the head
    do_store(30'hB0, 32'hB0B0B0B0, 4'hF);
    do_store(30'hB1, 32'hB1B1B1B1, 4'hF);
    do_store(30'hB2, 32'hB2B2B2B2, 4'hF);
    mem_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pulse_beat", 128'({mem_valid, mem_addr, mem_data, mem_be}),
        128'({1'b1, 30'hB0, 32'hB0B0B0B0, 4'hF}));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("pulse_idle", 128'({mem_valid, count}), 128'({1'b0, 4'd2}));
      tick();
    end
    mem_ready = 1'b0;
    exp_q.push_back(mk(30'hB1, 32'hB1B1B1B1, 4'hF));
    exp_q.push_back(mk(30'hB2, 32'hB2B2B2B2, 4'hF));
    drain_expected(200);

    // Reset while a beat is presented
    do_store(30'hA0, 32'hA0A0A0A0, 4'hF);
    do_store(30'hA1, 32'hA1A1A1A1, 4'hF);
    do_store(30'hA2, 32'hA2A2A2A2, 4'hF);
    do_store(30'hA3, 32'hA3A3A3A3, 4'hF);
    tick();
    chk("pre_reset_drain", 128'({mem_valid, mem_addr}), 128'({1'b1, 30'hA0}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 128'({mem_valid, count, empty}), 128'({1'b0, 4'd0, 1'b1}));
    chk_ld("reset_ld", 30'hA0, 1'b0, 32'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("no_replay", 128'({mem_valid, count}), 128'({1'b0, 4'd0}));
      tick();
    end
    mem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
